// File: rtl/da2_frame_serializer.sv
// Serializes complex DUC samples into 16-bit frames for a dual-channel 12-bit SPI DAC (Pmod DA2).
// A one-deep holding buffer decouples the unstallable sample stream from the frame timing.
module da2_frame_serializer #(
  parameter int CLK_DIV    = 2,
  parameter int QUIET_CYC  = 4,
  parameter bit OFFSET_BIN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sample_valid,
  input  logic [15:0] sample_re,
  input  logic [15:0] sample_im,
  output logic        dac_sclk,
  output logic        dac_d1,
  output logic        dac_d2,
  output logic        dac_sync_n,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun,
  output logic [15:0] overrun_cnt
);

  typedef enum logic [1:0] {IDLE, SHIFT_HI, SHIFT_LO, QUIET} state_t;

  localparam int MAX_CYC = (CLK_DIV > QUIET_CYC) ? CLK_DIV : QUIET_CYC;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] QUIET_LAST = CW'(QUIET_CYC - 1);
  localparam logic [11:0]   MSB_FLIP   = OFFSET_BIN ? 12'h800 : 12'h000;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic [14:0] sh_re_q, sh_re_d, sh_im_q, sh_im_d;
  logic [11:0] buf_re_q, buf_re_d, buf_im_q, buf_im_d;
  logic        buf_full_q, buf_full_d;
  logic        sclk_q, sclk_d, sync_n_q, sync_n_d;
  logic        d1_q, d1_d, d2_q, d2_d;
  logic        busy_q, busy_d, frame_done_q, frame_done_d, overrun_q, overrun_d;
  logic [15:0] overrun_cnt_q, overrun_cnt_d;
  logic        take;

  // Sub-LSB input bits are dropped by the truncating conversion.
  logic unused_lsbs;
  assign unused_lsbs = ^{sample_re[3:0], sample_im[3:0]};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    sh_re_d      = sh_re_q;
    sh_im_d      = sh_im_q;
    sclk_d       = sclk_q;
    sync_n_d     = sync_n_q;
    d1_d         = d1_q;
    d2_d         = d2_q;
    frame_done_d = 1'b0;
    take         = 1'b0;

    case (state_q)
      IDLE: take = buf_full_q;
      SHIFT_HI: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          sclk_d  = 1'b0;
          state_d = SHIFT_LO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT_LO: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d  = '0;
          sclk_d = 1'b1;
          if (bit_q != 4'd0) begin
            bit_d   = bit_q - 1'b1;
            d1_d    = sh_re_q[14];
            d2_d    = sh_im_q[14];
            sh_re_d = {sh_re_q[13:0], 1'b0};
            sh_im_d = {sh_im_q[13:0], 1'b0};
            state_d = SHIFT_HI;
          end else begin
            sync_n_d     = 1'b1;
            d1_d         = 1'b0;
            d2_d         = 1'b0;
            frame_done_d = 1'b1;
            state_d      = QUIET;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      QUIET: begin
        if (cnt_q == QUIET_LAST) begin
          cnt_d = '0;
          if (buf_full_q) take = 1'b1;
          else            state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Frame word MSB is always 0 (normal power-down mode), so it is presented directly.
    if (take) begin
      state_d  = SHIFT_HI;
      cnt_d    = '0;
      bit_d    = 4'd15;
      sh_re_d  = {3'b000, buf_re_q};
      sh_im_d  = {3'b000, buf_im_q};
      d1_d     = 1'b0;
      d2_d     = 1'b0;
      sync_n_d = 1'b0;
      sclk_d   = 1'b1;
    end

    buf_re_d   = buf_re_q;
    buf_im_d   = buf_im_q;
    buf_full_d = buf_full_q && !take;
    overrun_d  = 1'b0;
    if (sample_valid) begin
      buf_re_d   = sample_re[15:4] ^ MSB_FLIP;
      buf_im_d   = sample_im[15:4] ^ MSB_FLIP;
      buf_full_d = 1'b1;
      overrun_d  = buf_full_q && !take;
    end

    overrun_cnt_d = overrun_cnt_q;
    if (overrun_d && (overrun_cnt_q != 16'hFFFF)) overrun_cnt_d = overrun_cnt_q + 1'b1;

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bit_q         <= '0;
      sh_re_q       <= '0;
      sh_im_q       <= '0;
      buf_re_q      <= '0;
      buf_im_q      <= '0;
      buf_full_q    <= 1'b0;
      sclk_q        <= 1'b1;
      sync_n_q      <= 1'b1;
      d1_q          <= 1'b0;
      d2_q          <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
      overrun_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      sh_re_q       <= sh_re_d;
      sh_im_q       <= sh_im_d;
      buf_re_q      <= buf_re_d;
      buf_im_q      <= buf_im_d;
      buf_full_q    <= buf_full_d;
      sclk_q        <= sclk_d;
      sync_n_q      <= sync_n_d;
      d1_q          <= d1_d;
      d2_q          <= d2_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      overrun_q     <= overrun_d;
      overrun_cnt_q <= overrun_cnt_d;
    end
  end

  assign dac_sclk    = sclk_q;
  assign dac_sync_n  = sync_n_q;
  assign dac_d1      = d1_q;
  assign dac_d2      = d2_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign overrun     = overrun_q;
  assign overrun_cnt = overrun_cnt_q;

endmodule

// File: tb/tb_da2_frame_serializer.sv
// Bench for da2_frame_serializer: offset-binary (index 0) and two's-complement (index 1) instances
// share one stimulus stream; captured frames are checked against a sample-scheduling model.
module tb_da2_frame_serializer;

  localparam int CLK_DIV   = 2;
  localparam int QUIET_CYC = 4;
  localparam int FRAME_CYC = 32 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_re = '0;
  logic [15:0] sample_im = '0;

  logic [1:0]  sclk_w, d1_w, d2_w, sync_w, busy_w, fd_w, ov_w;
  logic [15:0] ocnt0, ocnt1;

  da2_frame_serializer #(.CLK_DIV(CLK_DIV), .QUIET_CYC(QUIET_CYC), .OFFSET_BIN(1'b1)) dut_ob (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid),
    .sample_re(sample_re), .sample_im(sample_im),
    .dac_sclk(sclk_w[0]), .dac_d1(d1_w[0]), .dac_d2(d2_w[0]), .dac_sync_n(sync_w[0]),
    .busy(busy_w[0]), .frame_done(fd_w[0]), .overrun(ov_w[0]), .overrun_cnt(ocnt0)
  );

  da2_frame_serializer #(.CLK_DIV(CLK_DIV), .QUIET_CYC(QUIET_CYC), .OFFSET_BIN(1'b0)) dut_tc (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid),
    .sample_re(sample_re), .sample_im(sample_im),
    .dac_sclk(sclk_w[1]), .dac_d1(d1_w[1]), .dac_d2(d2_w[1]), .dac_sync_n(sync_w[1]),
    .busy(busy_w[1]), .frame_done(fd_w[1]), .overrun(ov_w[1]), .overrun_cnt(ocnt1)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n++;

  typedef struct { logic [15:0] d1; logic [15:0] d2; int bits; int low; int start; int gap; } frame_t;
  typedef struct { logic [15:0] re; logic [15:0] im; int take; } exp_t;

  frame_t cap0[$];
  frame_t cap1[$];
  exp_t   exp_q[$];

  int errors = 0;
  int checks = 0;

  // Frame monitor: shifts data on each sclk fall inside a sync_n-low window.
  logic [15:0] acc1[2], acc2[2];
  int          nbits[2], nlow[2], nhigh[2], fstart[2], fgap[2];
  logic        prev_sclk[2], prev_sync[2];
  int          fd_cnt[2] = '{0, 0};
  int          ov_cnt[2] = '{0, 0};

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        acc1[k] = '0; acc2[k] = '0; nbits[k] = 0; nlow[k] = 0; nhigh[k] = 0;
        prev_sclk[k] = 1'b1; prev_sync[k] = 1'b1;
      end else begin
        if (prev_sync[k] && !sync_w[k]) begin
          fstart[k] = edge_n; fgap[k] = nhigh[k]; nhigh[k] = 0;
          nbits[k] = 0; nlow[k] = 0; acc1[k] = '0; acc2[k] = '0;
        end
        if (!sync_w[k]) nlow[k]++; else nhigh[k]++;
        if (prev_sclk[k] && !sclk_w[k] && !sync_w[k]) begin
          acc1[k] = {acc1[k][14:0], d1_w[k]};
          acc2[k] = {acc2[k][14:0], d2_w[k]};
          nbits[k]++;
        end
        if (!prev_sync[k] && sync_w[k]) begin
          frame_t f;
          f = '{acc1[k], acc2[k], nbits[k], nlow[k], fstart[k], fgap[k]};
          if (k == 0) cap0.push_back(f); else cap1.push_back(f);
        end
        if (fd_w[k]) fd_cnt[k]++;
        if (ov_w[k]) ov_cnt[k]++;
        prev_sclk[k] = sclk_w[k];
        prev_sync[k] = sync_w[k];
      end
    end
  end

  // Scheduling model: a buffered sample is sent at max(fill edge + 1, end of previous frame's quiet time).
  int   ready_edge = 0;
  bit   pend = 1'b0;
  exp_t pend_e;
  int   ov_exp = 0;

  function automatic logic [15:0] expWord(input logic [15:0] s, input bit ob);
    int v;
    v = int'($signed(s)) >>> 4;
    if (ob) v = v + 2048;
    v = ((v % 4096) + 4096) % 4096;
    return 16'(v);
  endfunction

  function void commitPending();
    exp_q.push_back(pend_e);
    ready_edge = pend_e.take + FRAME_CYC + QUIET_CYC;
    pend = 1'b0;
  endfunction

  function void modelValid(input int n, input logic [15:0] re, input logic [15:0] im);
    if (pend && pend_e.take <= n) commitPending();
    if (pend) begin
      ov_exp++;
      pend_e.re = re;
      pend_e.im = im;
    end else begin
      pend = 1'b1;
      pend_e = '{re, im, (n + 1 > ready_edge) ? n + 1 : ready_edge};
    end
  endfunction

  function void modelReset(input int now);
    if (pend && pend_e.take + FRAME_CYC <= now) commitPending();
    pend = 1'b0;
    ready_edge = 0;
    ov_exp = 0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
  endtask

  task automatic applyStimulus(input logic [15:0] re, input logic [15:0] im, input bit track);
    @(negedge clk);
    sample_valid = 1'b1;
    sample_re = re;
    sample_im = im;
    if (track) modelValid(edge_n + 1, re, im);
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic waitFrames(input string tag, input int n);
    int t;
    t = 0;
    while (cap0.size() < n && t < 2000) begin
      @(negedge clk); #1;
      t++;
    end
    checkOutput({tag, "_arrive"}, 32'(cap0.size() >= n), 32'd1);
  endtask

  task automatic cmpFrame(input string tag, input frame_t f, input exp_t e, input bit ob);
    checkOutput({tag, "_d1"}, f.d1, expWord(e.re, ob));
    checkOutput({tag, "_d2"}, f.d2, expWord(e.im, ob));
    checkOutput({tag, "_bits"}, f.bits, 16);
    checkOutput({tag, "_syncLow"}, f.low, FRAME_CYC);
    checkOutput({tag, "_startEdge"}, f.start, e.take);
  endtask

  task automatic settleAndCompare(input string tag);
    exp_t e;
    repeat (200) @(negedge clk);
    #1;
    if (pend) commitPending();
    checkOutput({tag, "_frames_ob"}, cap0.size(), exp_q.size());
    checkOutput({tag, "_frames_tc"}, cap1.size(), exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (cap0.size() > 0) cmpFrame({tag, "_ob"}, cap0.pop_front(), e, 1'b1);
      if (cap1.size() > 0) cmpFrame({tag, "_tc"}, cap1.pop_front(), e, 1'b0);
    end
    cap0.delete();
    cap1.delete();
  endtask

  initial begin
    int base_fd, base_ov, base_cnt;
    logic [15:0] third_re;

    $display("[TB] reset with random valids");
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      sample_valid = 1'($urandom);
      sample_re = 16'($urandom);
      sample_im = 16'($urandom);
      @(negedge clk);
      checkOutput("reset_pins", {sclk_w, sync_w, d1_w, d2_w, busy_w, fd_w, ov_w}, 32'h3C00);
      checkOutput("reset_ocnt", {ocnt0, ocnt1}, 32'h0);
    end
    sample_valid = 1'b0;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    checkOutput("post_reset_no_frame", cap0.size(), 0);

    $display("[TB] single frame");
    base_fd = fd_cnt[0];
    applyStimulus(16'h7FF0, 16'h8000, 1'b1);
    waitFrames("single", 1);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("single_d1", cap0[0].d1, 32'h0FFF);
    checkOutput("single_d2", cap0[0].d2, 32'h0000);
    checkOutput("single_low", cap0[0].low, 64);
    checkOutput("single_falls", cap0[0].bits, 16);
    checkOutput("single_done", fd_cnt[0] - base_fd, 1);
    settleAndCompare("single");

    $display("[TB] code conversion");
    applyStimulus(16'h0000, 16'h0000, 1'b1);
    waitFrames("zero", 1);
    checkOutput("zero_ob_d1", cap0[0].d1, 32'h0800);
    checkOutput("zero_ob_d2", cap0[0].d2, 32'h0800);
    checkOutput("zero_tc_d1", cap1[0].d1, 32'h0000);
    repeat (20) @(negedge clk);
    applyStimulus(16'hFFF0, 16'h0000, 1'b1);
    waitFrames("neg", 2);
    checkOutput("neg_tc_d1", cap1[1].d1, 32'h0FFF);
    checkOutput("neg_ob_d1", cap0[1].d1, 32'h07FF);
    settleAndCompare("conv");

    $display("[TB] back-to-back at 68-cycle rate");
    base_ov = ov_cnt[0];
    base_cnt = int'(ocnt0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(16'($urandom), 16'($urandom), 1'b1);
      repeat (66) @(negedge clk);
    end
    waitFrames("b2b", 10);
    for (int i = 1; i < 10 && i < cap0.size(); i++)
      checkOutput($sformatf("b2b_gap%0d", i), 32'(cap0[i].gap >= QUIET_CYC), 32'd1);
    checkOutput("b2b_overrun_pulses", ov_cnt[0] - base_ov, 0);
    checkOutput("b2b_overrun_cnt", int'(ocnt0) - base_cnt, 0);
    settleAndCompare("b2b");

    $display("[TB] overrun");
    base_ov = ov_cnt[0];
    base_cnt = int'(ocnt0);
    third_re = 16'h1230;
    applyStimulus(16'h4560, 16'hABC0, 1'b1);
    repeat (3) @(negedge clk);
    applyStimulus(16'h7770, 16'h1110, 1'b1);
    repeat (3) @(negedge clk);
    applyStimulus(third_re, 16'hCDE0, 1'b1);
    waitFrames("ovr", 2);
    checkOutput("ovr_pulses", ov_cnt[0] - base_ov, 1);
    checkOutput("ovr_cnt", int'(ocnt0) - base_cnt, 1);
    checkOutput("ovr_second_frame", cap0[1].d1, expWord(third_re, 1'b1));
    settleAndCompare("ovr");

    $display("[TB] reset mid-frame");
    applyStimulus(16'h5A50, 16'hA5A0, 1'b1);
    begin
      int t;
      t = 0;
      while (nbits[0] < 7 && t < 500) begin
        @(negedge clk); #1;
        t++;
      end
      checkOutput("midrst_reach7", 32'(nbits[0] >= 7), 32'd1);
    end
    rst_n = 1'b0;
    #1;
    modelReset(edge_n);
    checkOutput("midrst_pins", {sclk_w, sync_w, d1_w, d2_w, busy_w}, 32'h3C0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    #1;
    checkOutput("midrst_no_frame", cap0.size(), 0);
    checkOutput("midrst_idle", {busy_w, sync_w}, 32'h3);
    applyStimulus(16'h3C30, 16'hC3C0, 1'b1);
    settleAndCompare("midrst");

    $display("[TB] random traffic");
    for (int i = 0; i < 30; i++) begin
      applyStimulus(16'($urandom), 16'($urandom), 1'b1);
      repeat ($urandom_range(3, 150)) @(negedge clk);
    end
    settleAndCompare("rand");
    checkOutput("rand_ocnt_ob", ocnt0, ov_exp);
    checkOutput("rand_ocnt_tc", ocnt1, ov_exp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
